// File: rtl/fan_pkg.sv
// Shared definitions for the fan head swing scheduler and pwm_512step users.
package fan_pkg;

  localparam int unsigned DUTY_W = 9;

  // Default servo positions in pwm_512step duty steps.
  localparam int unsigned DEF_DUTY_MIN    = 8;
  localparam int unsigned DEF_DUTY_MAX    = 70;
  localparam int unsigned DEF_DUTY_CENTER = 39;
  localparam int unsigned DEF_NARROW_HALF = 12;
  localparam int unsigned DEF_STEP_DIV    = 8_388_608;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WIDE   = 2'd1,
    ST_NARROW = 2'd2,
    ST_RETURN = 2'd3
  } state_e;

  // One duty step from cur toward target. Returns cur unchanged when already there.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] target);
    if (cur < target)      return cur + DUTY_W'(1);
    else if (cur > target) return cur - DUTY_W'(1);
    else                   return cur;
  endfunction

endpackage

// File: rtl/swing_step_timer.sv
// Free-running divider that emits a one-cycle tick every STEP_DIV clocks.
module swing_step_timer #(
  parameter int unsigned STEP_DIV = fan_pkg::DEF_STEP_DIV
) (
  input  logic clk,
  input  logic reset_p,
  output logic tick
);

  localparam int unsigned     CNT_W = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Tick on the last count and wrap to zero; never paused by the FSM.
  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // Counter register with synchronous reset.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset_p) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fan_swing_ctrl.sv
// Swing scheduler: turns mode pulses and the motor switch into a servo duty sweep.
module fan_swing_ctrl
  import fan_pkg::*;
#(
  parameter int unsigned DUTY_MIN    = DEF_DUTY_MIN,
  parameter int unsigned DUTY_MAX    = DEF_DUTY_MAX,
  parameter int unsigned DUTY_CENTER = DEF_DUTY_CENTER,
  parameter int unsigned NARROW_HALF = DEF_NARROW_HALF,
  parameter int unsigned STEP_DIV    = DEF_STEP_DIV
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              mode_pe,
  input  logic              motor_sw,
  output logic [DUTY_W-1:0] duty,
  output logic [1:0]        state,
  output logic              busy
);

  localparam logic [DUTY_W-1:0] WIDE_LO   = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] WIDE_HI   = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] CENTER    = DUTY_W'(DUTY_CENTER);
  localparam logic [DUTY_W-1:0] NARROW_LO = DUTY_W'(DUTY_CENTER - NARROW_HALF);
  localparam logic [DUTY_W-1:0] NARROW_HI = DUTY_W'(DUTY_CENTER + NARROW_HALF);

  logic              tick;
  state_e            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              dir_q, dir_d;
  logic              busy_q, busy_d;
  logic [DUTY_W-1:0] lo, hi;

  swing_step_timer #(
    .STEP_DIV (STEP_DIV)
  ) u_timer (
    .clk     (clk),
    .reset_p (reset_p),
    .tick    (tick)
  );

  // Next state, duty and direction; the step always follows the current state's rule.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    lo      = (state_q == ST_NARROW) ? NARROW_LO : WIDE_LO;
    hi      = (state_q == ST_NARROW) ? NARROW_HI : WIDE_HI;

    unique case (state_q)
      ST_IDLE: begin
        if (mode_pe && motor_sw) state_d = ST_WIDE;
      end
      ST_WIDE, ST_NARROW: begin
        // Motor off beats a simultaneous mode press.
        if (!motor_sw)    state_d = ST_RETURN;
        else if (mode_pe) state_d = (state_q == ST_WIDE) ? ST_NARROW : ST_IDLE;

        // Bounce between lo and hi; out-of-window duty simply walks back in.
        if (tick) begin
          if (dir_q) begin
            if (duty_q >= hi) begin
              dir_d  = 1'b0;
              duty_d = duty_q - DUTY_W'(1);
            end else begin
              duty_d = duty_q + DUTY_W'(1);
            end
          end else begin
            if (duty_q <= lo) begin
              dir_d  = 1'b1;
              duty_d = duty_q + DUTY_W'(1);
            end else begin
              duty_d = duty_q - DUTY_W'(1);
            end
          end
        end
      end
      ST_RETURN: begin
        if (duty_q == CENTER) state_d = ST_IDLE;
        else if (tick)        duty_d  = step_toward(duty_q, CENTER);
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // FSM and datapath registers; busy is registered alongside state so both move together.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q <= ST_IDLE;
      duty_q  <= CENTER;
      dir_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
    end
  end

  assign duty  = duty_q;
  assign state = state_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_fan_swing_ctrl.sv
// Directed bench for fan_swing_ctrl with STEP_DIV=4 and default bounds.
module tb_fan_swing_ctrl;

  logic       clk = 1'b0;
  logic       reset_p;
  logic       mode_pe;
  logic       motor_sw;
  logic [8:0] duty;
  logic [1:0] state;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Reference model of the head position.
  int exp_duty;
  int exp_dir;

  typedef struct {
    logic mode_pe;
    logic motor_sw;
    int   ncyc;
    int   exp_state;
    int   exp_duty;
    int   exp_busy;
  } vec_t;

  vec_t vecs[8];

  fan_swing_ctrl #(
    .STEP_DIV (4)
  ) dut (
    .clk      (clk),
    .reset_p  (reset_p),
    .mode_pe  (mode_pe),
    .motor_sw (motor_sw),
    .duty     (duty),
    .state    (state),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input int st, input int d, input int b);
    check({name, ".state"}, int'(state), st);
    check({name, ".duty"},  int'(duty),  d);
    check({name, ".busy"},  int'(busy),  b);
  endtask

  // Advance the model one tick inside [lo, hi].
  task automatic model_step(input int lo, input int hi);
    if (exp_dir == 1) begin
      if (exp_duty >= hi) begin exp_dir = 0; exp_duty--; end
      else exp_duty++;
    end else begin
      if (exp_duty <= lo) begin exp_dir = 1; exp_duty++; end
      else exp_duty--;
    end
  endtask

  // n ticks of sweeping; the first tick edge is first_gap clocks away.
  task automatic sweep(input int n, input int lo, input int hi, input int st, input int first_gap);
    for (int i = 0; i < n; i++) begin
      clocks(i == 0 ? first_gap : 4);
      model_step(lo, hi);
      check("sweep.duty", int'(duty), exp_duty);
      check("sweep.state", int'(state), st);
    end
  endtask

  initial begin
    // Edge count k after the last reset edge; tick edges fall on k % 4 == 0.
    vecs[0] = '{1'b0, 1'b0, 3, 0, 39, 0};  // k=3  idle stable
    vecs[1] = '{1'b0, 1'b0, 7, 0, 39, 0};  // k=10 idle stable
    vecs[2] = '{1'b1, 1'b0, 1, 0, 39, 0};  // k=11 mode ignored, motor off
    vecs[3] = '{1'b1, 1'b1, 1, 1, 39, 1};  // k=12 enter WIDE on tick edge, IDLE rule: no step
    vecs[4] = '{1'b0, 1'b1, 4, 1, 40, 1};  // k=16 first step up
    vecs[5] = '{1'b0, 1'b1, 4, 1, 41, 1};  // k=20
    vecs[6] = '{1'b0, 1'b1, 2, 1, 41, 1};  // k=22 held between ticks
    vecs[7] = '{1'b0, 1'b1, 2, 1, 42, 1};  // k=24

    reset_p  = 1'b1;
    mode_pe  = 1'b0;
    motor_sw = 1'b0;
    clocks(2);
    check_out("reset", 0, 39, 0);
    reset_p = 1'b0;

    foreach (vecs[i]) begin
      mode_pe  = vecs[i].mode_pe;
      motor_sw = vecs[i].motor_sw;
      clocks(1);
      mode_pe = 1'b0;
      if (vecs[i].ncyc > 1) clocks(vecs[i].ncyc - 1);
      check_out($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_duty, vecs[i].exp_busy);
    end

    // Wide sweep: 42 up to 70, down to 8, back to 9, then on up to 65.
    exp_duty = 42;
    exp_dir  = 1;
    sweep(91, 8, 70, 1, 4);
    check("wide.bottom_bounce", int'(duty), 9);
    sweep(56, 8, 70, 1, 4);

    // Switch to NARROW at 65 moving up: walk down into 27..51 and bounce to 45.
    mode_pe = 1'b1;
    clocks(1);
    mode_pe = 1'b0;
    check_out("to_narrow", 2, 65, 1);
    sweep(68, 27, 51, 2, 3);
    check("narrow.at45", int'(duty), 45);

    // Motor off together with mode press: RETURN wins.
    mode_pe  = 1'b1;
    motor_sw = 1'b0;
    clocks(1);
    mode_pe = 1'b0;
    check_out("to_return", 3, 45, 1);
    for (int d = 44; d >= 39; d--) begin
      clocks(d == 44 ? 3 : 4);
      check_out("return", 3, d, 1);
    end
    clocks(1);
    check_out("return_done", 0, 39, 0);

    // IDLE ignores mode with motor off.
    mode_pe = 1'b1;
    clocks(1);
    mode_pe = 1'b0;
    check_out("idle_motor_off", 0, 39, 0);

    // Re-enter WIDE: stored dir is down.
    motor_sw = 1'b1;
    mode_pe  = 1'b1;
    clocks(1);
    mode_pe = 1'b0;
    check_out("wide_again", 1, 39, 1);
    clocks(1);
    check_out("wide_dir_kept", 1, 38, 1);
    mode_pe = 1'b1;
    clocks(1);
    mode_pe = 1'b0;
    check_out("narrow_again", 2, 38, 1);
    clocks(3);
    check_out("narrow_step", 2, 37, 1);
    mode_pe = 1'b1;
    clocks(1);
    mode_pe = 1'b0;
    check_out("third_press_idle", 0, 37, 0);
    clocks(3);
    check_out("idle_frozen", 0, 37, 0);

    // Mode press in the tick cycle: the step uses IDLE's rule on that edge.
    clocks(3);
    mode_pe = 1'b1;
    clocks(1);
    mode_pe = 1'b0;
    check_out("mode_on_tick", 1, 37, 1);
    clocks(4);
    check_out("mode_on_tick_next", 1, 36, 1);

    // Sweep down to 8 and back up to 60, then reset mid-sweep.
    exp_duty = 36;
    exp_dir  = 0;
    sweep(80, 8, 70, 1, 4);
    check("wide.at60", int'(duty), 60);
    clocks(1);
    reset_p = 1'b1;
    clocks(1);
    reset_p = 1'b0;
    check_out("mid_reset", 0, 39, 0);
    mode_pe = 1'b1;
    clocks(1);
    mode_pe = 1'b0;
    check_out("post_reset_wide", 1, 39, 1);
    clocks(1);
    check_out("post_reset_no_old_tick", 1, 39, 1);
    clocks(1);
    check_out("post_reset_pre_tick", 1, 39, 1);
    clocks(1);
    check_out("post_reset_tick_up", 1, 40, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
